// File: rtl/dnn_seq_pkg.sv
// Shared types and command-field layout for the DNN phase sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dnn_seq_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_FWD = 4'd1,
    OP_BWD = 4'd2,
    OP_UPD = 4'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Command word layout: [15:12] op, [11:8] layer, [7:4] rd_bank, [3:0] wr_bank.
  localparam int CMD_FLD_W     = 4;
  localparam int CMD_OP_LSB    = 12;
  localparam int CMD_LAYER_LSB = 8;
  localparam int CMD_RDB_LSB   = 4;
  localparam int CMD_WRB_LSB   = 0;

  // Only opcodes 0..3 are defined; everything above is rejected with err.
  function automatic logic op_is_legal(input logic [CMD_FLD_W-1:0] op);
    return (op <= 4'd3);
  endfunction

endpackage

// File: rtl/seq_delay_line.sv
// Enable-gated shift register aligning read-cycle control with the datapath.
// Latency: exactly LAT enabled cycles from din_i to dout_o.
// Backpressure: enable low freezes every stage; nothing is dropped or duplicated.
module seq_delay_line #(
  parameter int W   = 11,
  parameter int LAT = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o
);

  logic [LAT-1:0][W-1:0] stg_q;

  // Shift one stage per enabled cycle; stage 0 captures the read-cycle control.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stg_q <= '0;
    end else if (enable) begin
      stg_q[0] <= din_i;
      for (int i = 1; i < LAT; i++) begin
        stg_q[i] <= stg_q[i-1];
      end
    end
  end

  assign dout_o = stg_q[LAT-1];

endmodule

// File: rtl/dnn_phase_sequencer.sv
// Command-driven FWD/BWD/UPD pass sequencer over a ROWS x COLS tile (optional PERF_CNT_EN perf counters).
// Latency: reads start the cycle after accept; done follows the last write (FWD/BWD: 96+LAT+2, UPD: 96+LAT+1).
// Backpressure: one command at a time (cmd_ready only in IDLE); enable low freezes everything and gates all strobes.
module dnn_phase_sequencer
  import dnn_seq_pkg::*;
#(
  parameter int ROWS   = 8,
  parameter int COLS   = 12,
  parameter int ADDR_W = 8,
  parameter int LAT    = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [31:0]       cmd,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [3:0]        rd_bank,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [3:0]        wr_bank,
  output logic              acc_clear,
  output logic              acc_en,
  output logic [3:0]        layer,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]       perf_busy_cycles,
  output logic [31:0]       perf_cmds
`endif
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DW = $clog2(LAT + 1);
  localparam int DLW = ADDR_W + 3;
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  state_e            state_q;
  op_e               op_q;
  logic [RW-1:0]     row_q, row_d;
  logic [CW-1:0]     col_q, col_d;
  logic [DW-1:0]     drain_q;
  logic              err_q;
  logic [3:0]        layer_q, rd_bank_q, wr_bank_q;
  logic              wr_post_q;
  logic [ADDR_W-1:0] wr_addr_post_q;

  logic [CMD_FLD_W-1:0] op_fld;
  logic                 cmd_unused;
  logic                 issuing, last_elem, grp_first, grp_last, is_upd, is_bwd;
  logic [ADDR_W-1:0]    grp_addr;
  logic [DLW-1:0]       dl_in, dl_out;
  logic                 dl_acc, dl_clr, dl_wr;
  logic [ADDR_W-1:0]    dl_addr;

  assign op_fld     = cmd[CMD_OP_LSB +: CMD_FLD_W];
  assign cmd_unused = ^cmd[31:16];

  assign issuing   = (state_q == ST_ISSUE);
  assign is_upd    = (op_q == OP_UPD);
  assign is_bwd    = (op_q == OP_BWD);
  assign last_elem = (row_q == ROW_LAST) && (col_q == COL_LAST);
  // A group is a row for FWD/UPD and a column for BWD.
  assign grp_first = is_bwd ? (row_q == '0) : (col_q == '0);
  assign grp_last  = is_bwd ? (row_q == ROW_LAST) : (col_q == COL_LAST);
  assign grp_addr  = is_bwd ? ADDR_W'(col_q) : ADDR_W'(row_q);

  assign rd_addr   = ADDR_W'(row_q) * ADDR_W'(COLS) + ADDR_W'(col_q);
  assign cmd_ready = enable && !reset && (state_q == ST_IDLE);
  assign rd_en     = enable && issuing;
  assign busy      = (state_q != ST_IDLE);
  assign done      = enable && (state_q == ST_DONE);
  assign err       = enable && err_q;
  assign layer     = layer_q;
  assign rd_bank   = rd_bank_q;
  assign wr_bank   = wr_bank_q;

  // Advance the tile walk: column inner for FWD/UPD, row inner for BWD, wrapping at the ends.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (is_bwd) begin
      if (row_q == ROW_LAST) begin
        row_d = '0;
        col_d = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
      end else begin
        row_d = row_q + 1'b1;
      end
    end else begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Pass FSM: accept/decode, issue reads, drain the pipeline, pulse done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_NOP;
      row_q     <= '0;
      col_q     <= '0;
      drain_q   <= '0;
      err_q     <= 1'b0;
      layer_q   <= '0;
      rd_bank_q <= '0;
      wr_bank_q <= '0;
    end else if (enable) begin
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            layer_q   <= cmd[CMD_LAYER_LSB +: CMD_FLD_W];
            rd_bank_q <= cmd[CMD_RDB_LSB +: CMD_FLD_W];
            wr_bank_q <= cmd[CMD_WRB_LSB +: CMD_FLD_W];
            if (op_is_legal(op_fld)) begin
              op_q    <= op_e'(op_fld);
              state_q <= (op_fld == OP_NOP) ? ST_DONE : ST_ISSUE;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          row_q <= row_d;
          col_q <= col_d;
          if (last_elem) begin
            state_q <= ST_DRAIN;
            // FWD/BWD writes trail the delay line by one extra register.
            drain_q <= is_upd ? DW'(LAT - 1) : DW'(LAT);
          end
        end
        ST_DRAIN: begin
          if (drain_q == '0) begin
            state_q <= ST_DONE;
          end else begin
            drain_q <= drain_q - 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign dl_in = {issuing,
                  issuing && !is_upd && grp_first,
                  issuing && (is_upd || grp_last),
                  is_upd ? rd_addr : grp_addr};

  seq_delay_line #(
    .W   (DLW),
    .LAT (LAT)
  ) u_delay (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .din_i  (dl_in),
    .dout_o (dl_out)
  );

  assign {dl_acc, dl_clr, dl_wr, dl_addr} = dl_out;

  // Group results are written one cycle after the group's final accumulate lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_post_q      <= 1'b0;
      wr_addr_post_q <= '0;
    end else if (enable) begin
      wr_post_q      <= dl_wr && !is_upd;
      wr_addr_post_q <= dl_addr;
    end
  end

  assign acc_en    = enable && dl_acc;
  assign acc_clear = enable && dl_clr;
  assign wr_en     = enable && (is_upd ? dl_wr : wr_post_q);
  assign wr_addr   = is_upd ? dl_addr : wr_addr_post_q;

`ifdef PERF_CNT_EN
  logic [31:0] perf_busy_q, perf_cmds_q;

  // Saturating activity counters: busy enabled cycles and accepted legal commands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_busy_q <= '0;
      perf_cmds_q <= '0;
    end else if (enable) begin
      if (busy && (perf_busy_q != 32'hFFFF_FFFF)) begin
        perf_busy_q <= perf_busy_q + 1'b1;
      end
      if (cmd_ready && cmd_valid && op_is_legal(op_fld) && (perf_cmds_q != 32'hFFFF_FFFF)) begin
        perf_cmds_q <= perf_cmds_q + 1'b1;
      end
    end
  end

  assign perf_busy_cycles = perf_busy_q;
  assign perf_cmds        = perf_cmds_q;
`endif

endmodule

// File: doc/dnn_phase_sequencer.md
Name: dnn_phase_sequencer

Overview:
- Command-driven sequencer for the DNN training datapath (PE accumulator plus weight/activation buffers); sits between the top-level controller's mode decode and the datapath.
- Accepts one 32-bit command at a time and sequences forward, backward or update passes over a ROWS x COLS tile.
- Generates buffer read/write strobes and addresses, and accumulator clear/enable, aligned to the datapath pipeline latency.
- Reports completion with a done pulse and illegal commands with an err pulse.

Parameters:
- ROWS, 8, output neurons per tile.
- COLS, 12, inputs per tile (ROWS*COLS = 96 elements).
- ADDR_W, 8, element address width; must satisfy 2^ADDR_W >= ROWS*COLS.
- LAT, 3, datapath cycles from rd_en to valid accumulate (>= 1).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- enable  in  1  global advance; low freezes all state
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd  in  32  [15:12] op, [11:8] layer, [7:4] rd_bank, [3:0] wr_bank; [31:16] ignored
- rd_en  out  1  buffer read strobe
- rd_addr  out  ADDR_W  element index, row*COLS+col
- rd_bank  out  4  latched cmd[7:4]
- wr_en  out  1  result write strobe
- wr_addr  out  ADDR_W  result index
- wr_bank  out  4  latched cmd[3:0]
- acc_clear  out  1  accumulator clear, coincident with first acc_en of a row or column group
- acc_en  out  1  accumulate this cycle
- layer  out  4  latched cmd[11:8]
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle illegal-op pulse

Behaviour:
- Reset: all outputs 0 and state IDLE; delay pipeline, counters and latched fields cleared. Reset is legal mid-pass and aborts it with no done.
- States: IDLE, ISSUE, DRAIN, DONE.
- Acceptance: cmd_ready = enable && state==IDLE. Accept cycle is T.
- Opcodes:
  - 0 NOP: DONE at T+1, no strobes.
  - 1 FWD, 2 BWD, 3 UPD: ISSUE from T+1.
  - 4..15 illegal: err high at T+1, stay IDLE, no done.
- ISSUE: one rd_en per enabled cycle, ROWS*COLS cycles total.
  - FWD and UPD: row-major order (col inner).
  - BWD: column-major order (row inner); rd_addr is still row*COLS+col.
- Delay line: acc_en, acc_clear and write info are the read-cycle control delayed by LAT.
- FWD writes: wr_en for row r at (last read of row r)+LAT+1, wr_addr=r. 8 writes.
- BWD writes: wr_en for column c at (last read of column c)+LAT+1, wr_addr=c. 12 writes.
- UPD writes: wr_en for every element at its read+LAT, wr_addr=rd_addr. No acc_clear; acc_en is still pulsed.
- DRAIN: entered after the final read; waits until the final wr_en has issued. DONE follows the cycle after the last wr_en, with done=1 for one cycle. Next cycle is IDLE.
- Stall: enable low freezes the FSM, counters and delay line. rd_en, wr_en, acc_en, acc_clear, done and err are forced 0 while enable is low. The pass resumes exactly where it stopped.
- Counters wrap from ROWS-1/COLS-1 to 0; there is no overrun past ROWS*COLS.
- Latched fields (layer, rd_bank, wr_bank) hold their values until the next accept.

Optional Feature:
- Macro PERF_CNT_EN.
- Defined: adds 32-bit outputs perf_busy_cycles and perf_cmds.
  - perf_busy_cycles counts enabled cycles with busy=1.
  - perf_cmds counts accepted legal commands.
  - Both saturate at 2^32-1 and clear on reset.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package dnn_seq_pkg:
  - op enum (OP_NOP=0, OP_FWD=1, OP_BWD=2, OP_UPD=3).
  - state enum.
  - cmd field bit-position constants.
- Sub-module seq_delay_line: LAT-deep, enable-gated shift register carrying {acc_en, acc_clear, wr_flag, wr_addr}.

Test Plan (ROWS=8, COLS=12, LAT=3; accept at cycle T):
- FWD cmd 0x1000 -> rd_en T+1..T+96 with rd_addr 0..95; acc_clear at T+4, T+16, ..., T+88; wr_en at T+16+12k with wr_addr k=0..7 (last at T+100); done at T+101.
- BWD cmd 0x2000 -> rd_addr sequence 0,12,...,84,1,13,...,95; 12 writes with wr_addr 0..11, last at T+100; done at T+101.
- UPD cmd 0x3000 -> 96 wr_en, each equal to rd_addr delayed 3 cycles; no acc_clear; last write at T+99; done at T+100.
- FWD with enable low for 5 cycles starting at T+40 -> no strobes during the stall; address sequence unchanged; done at T+106.
- Illegal cmd 0x7000 -> err at T+1; no rd_en or done; cmd_ready high at T+1. NOP cmd 0x0000 -> done at T+1.
- Reset asserted at T+50 of FWD -> all outputs 0 immediately; no done; next FWD behaves as in the first scenario.
